rect_loop_sequencer: RTL and testbench

- Upstream stage of flip_controller in the Rectangle Loop datapath.
- Accepts one job (matrix base address) and enumerates every axis-aligned rectangle (r1<r2, c1<c2) of a ROWS x COLS matrix.
- For each rectangle, issues one flip request to flip_controller and waits for its done before issuing the next.
- Reports completion, the number of rectangles flipped, and a watchdog timeout error.

---
 rtl/rect_loop_pkg.sv | 56 +++++
 rtl/rect_loop_sequencer_rect_enum.sv | 47 ++++
 rtl/rect_loop_sequencer.sv | 157 +++++++++++++++
 tb/tb_rect_loop_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_loop_pkg.sv
// Shared types and the rectangle-stepping rule for the rectangle loop sequencer.
package rect_loop_pkg;

    // Internal corner width; the top narrows corners to its IDX_W on the ports.
    localparam int unsigned RIDX_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef struct packed {
        logic [RIDX_W-1:0] r1;
        logic [RIDX_W-1:0] r2;
        logic [RIDX_W-1:0] c1;
        logic [RIDX_W-1:0] c2;
    } rect_t;

    typedef struct packed {
        rect_t rect;
        logic  last;
    } rect_step_t;

    localparam rect_t RECT_FIRST = '{r1: 8'd0, r2: 8'd1, c1: 8'd0, c2: 8'd1};

    // Next rectangle in c2 -> c1 -> r2 -> r1 order; last=1 when cur is the final one.
    function automatic rect_step_t next_rect(input rect_t cur,
                                             input int unsigned rows,
                                             input int unsigned cols);
        rect_step_t step;
        step.rect = cur;
        step.last = 1'b0;
        if (32'(cur.c2) < cols - 32'd1) begin
            step.rect.c2 = RIDX_W'(cur.c2 + RIDX_W'(1));
        end else if (32'(cur.c1) < cols - 32'd2) begin
            step.rect.c1 = RIDX_W'(cur.c1 + RIDX_W'(1));
            step.rect.c2 = RIDX_W'(cur.c1 + RIDX_W'(2));
        end else if (32'(cur.r2) < rows - 32'd1) begin
            step.rect.c1 = '0;
            step.rect.c2 = RIDX_W'(1);
            step.rect.r2 = RIDX_W'(cur.r2 + RIDX_W'(1));
        end else if (32'(cur.r1) < rows - 32'd2) begin
            step.rect.c1 = '0;
            step.rect.c2 = RIDX_W'(1);
            step.rect.r1 = RIDX_W'(cur.r1 + RIDX_W'(1));
            step.rect.r2 = RIDX_W'(cur.r1 + RIDX_W'(2));
        end else begin
            step.last = 1'b1;
        end
        return step;
    endfunction

endpackage

// File: rtl/rect_loop_sequencer_rect_enum.sv
// Corner registers of the current rectangle plus the advance/last logic.
module rect_enum
    import rect_loop_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  logic  advance_i,
    output rect_t rect_o,
    output logic  last_c_o
);

    rect_t      rect_q;
    rect_t      rect_d;
    rect_step_t step_c;

    // Successor of the current rectangle and whether the current one is the last.
    always_comb begin
        step_c = next_rect(rect_q, ROWS, COLS);
    end

    // Load the first rectangle on job accept, otherwise step when told to.
    always_comb begin
        rect_d = rect_q;
        if (load_i) begin
            rect_d = RECT_FIRST;
        end else if (advance_i && !step_c.last) begin
            rect_d = step_c.rect;
        end
    end

    // Corner state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rect_q <= RECT_FIRST;
        end else begin
            rect_q <= rect_d;
        end
    end

    assign rect_o   = rect_q;
    assign last_c_o = step_c.last;

endmodule

// File: rtl/rect_loop_sequencer.sv
// Walks every rectangle of a ROWS x COLS matrix, one flip request at a time.
module rect_loop_sequencer
    import rect_loop_pkg::*;
#(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base_addr,
    input  logic              abort,
    output logic              flip_start,
    output logic [ADDR_W-1:0] flip_base_addr,
    output logic [IDX_W-1:0]  r1,
    output logic [IDX_W-1:0]  r2,
    output logic [IDX_W-1:0]  c1,
    output logic [IDX_W-1:0]  c2,
    input  logic              flip_done,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  rect_count
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              job_ready_q, flip_start_q, busy_q, done_q;
    logic              load_c, advance_c, last_c;
    rect_t             rect_c;
    logic              unused_rect_c;

    rect_enum #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rect_enum (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_c),
        .advance_i (advance_c),
        .rect_o    (rect_c),
        .last_c_o  (last_c)
    );

    // Next state, watchdog, counters and corner-stepping strobes.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        load_c    = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    state_d = ISSUE;
                    addr_d  = job_base_addr;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    load_c  = 1'b1;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (flip_done) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = ADVANCE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if ((wd_q + WD_W'(1)) == WD_W'(TIMEOUT_CYC)) begin
                        tmo_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ADVANCE: begin
                if (last_c) begin
                    state_d = DONE;
                end else begin
                    advance_c = 1'b1;
                    state_d   = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides everything, including a flip_done in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            wd_d      = wd_q;
            cnt_d     = cnt_q;
            tmo_d     = tmo_q;
            advance_c = 1'b0;
        end
    end

    // State, datapath and registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
            addr_q       <= '0;
            job_ready_q  <= 1'b1;
            flip_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            addr_q       <= addr_d;
            job_ready_q  <= (state_d == IDLE);
            flip_start_q <= (state_d == ISSUE);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    // Corner bits above IDX_W stay zero for any ROWS/COLS that fit IDX_W.
    assign unused_rect_c = ^rect_c;

    assign job_ready      = job_ready_q;
    assign flip_start     = flip_start_q;
    assign flip_base_addr = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout_err    = tmo_q;
    assign rect_count     = cnt_q;
    assign r1             = IDX_W'(rect_c.r1);
    assign r2             = IDX_W'(rect_c.r2);
    assign c1             = IDX_W'(rect_c.c1);
    assign c2             = IDX_W'(rect_c.c2);

endmodule

// File: tb/tb_rect_loop_sequencer.sv
// Scoreboard bench: 4x4 sequencer with a randomized flip_controller model, plus a 2x3 instance.
module tb_rect_loop_sequencer;

    localparam int TMO_A = 16;
    localparam int GAP_NONE = 0, GAP_FD2 = 1, GAP_DONE2 = 2, GAP_START = 3;
    localparam int END_NONE = 0, END_NORM = 1, END_TMO = 2;

    typedef struct {
        int kind;
        int r1, r2, c1, c2;
        int addr;
        int cnt;
        int tmo;
        int gap;
    } exp_t;

    typedef struct {
        int r1, r2, c1, c2;
    } mrect_t;

    logic clk, reset;

    // 4x4 instance signals
    logic       a_job_valid, a_job_ready, a_abort, a_flip_start, a_busy, a_done, a_tmo;
    logic [7:0] a_addr, a_flip_addr, a_cnt;
    logic [1:0] a_r1, a_r2, a_c1, a_c2;
    logic       fd_resp, fd_force, a_fd;

    // 2x3 instance signals
    logic       b_job_valid, b_job_ready, b_abort, b_flip_start, b_busy, b_done, b_tmo, b_fd;
    logic [7:0] b_addr, b_flip_addr, b_cnt;
    logic [1:0] b_r1, b_r2, b_c1, b_c2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t   exp_q[$];
    mrect_t model_q[$];
    mrect_t b_obs_q[$];

    int fs_cnt = 0;
    int resp_upto = 0;
    int lat_lo = 3, lat_hi = 3;
    bit glitch_en = 1'b0;
    int last_fd_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
    int done_seen = 0;
    int b_done_n = 0, b_done_cnt = 0;

    assign a_fd = fd_resp | fd_force;

    rect_loop_sequencer #(
        .ROWS(4), .COLS(4), .ADDR_W(8), .IDX_W(2), .CNT_W(8), .TIMEOUT_CYC(TMO_A)
    ) dut_a (
        .clk(clk), .reset(reset), .job_valid(a_job_valid), .job_ready(a_job_ready),
        .job_base_addr(a_addr), .abort(a_abort), .flip_start(a_flip_start),
        .flip_base_addr(a_flip_addr), .r1(a_r1), .r2(a_r2), .c1(a_c1), .c2(a_c2),
        .flip_done(a_fd), .busy(a_busy), .done(a_done), .timeout_err(a_tmo),
        .rect_count(a_cnt)
    );

    rect_loop_sequencer #(
        .ROWS(2), .COLS(3), .ADDR_W(8), .IDX_W(2), .CNT_W(8), .TIMEOUT_CYC(64)
    ) dut_b (
        .clk(clk), .reset(reset), .job_valid(b_job_valid), .job_ready(b_job_ready),
        .job_base_addr(b_addr), .abort(b_abort), .flip_start(b_flip_start),
        .flip_base_addr(b_flip_addr), .r1(b_r1), .r2(b_r2), .c1(b_c1), .c2(b_c2),
        .flip_done(b_fd), .busy(b_busy), .done(b_done), .timeout_err(b_tmo),
        .rect_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s act=event exp=none (cycle %0d)", name, cyc);
    endfunction

    // All rectangles r1<r2, c1<c2 in the required order.
    function automatic void build_list(input int rows, input int cols);
        mrect_t m;
        model_q.delete();
        for (int i1 = 0; i1 < rows - 1; i1++)
            for (int i2 = i1 + 1; i2 < rows; i2++)
                for (int j1 = 0; j1 < cols - 1; j1++)
                    for (int j2 = j1 + 1; j2 < cols; j2++) begin
                        m.r1 = i1; m.r2 = i2; m.c1 = j1; m.c2 = j2;
                        model_q.push_back(m);
                    end
    endfunction

    // Expected flip_starts of a 4x4 job, optionally followed by its done pulse.
    function automatic void push_job(input int addr, input int nflips, input int endk,
                                     input int first_gap);
        exp_t e;
        build_list(4, 4);
        for (int i = 0; i < nflips; i++) begin
            e.kind = 0;
            e.r1 = model_q[i].r1; e.r2 = model_q[i].r2;
            e.c1 = model_q[i].c1; e.c2 = model_q[i].c2;
            e.addr = addr; e.cnt = 0; e.tmo = 0;
            e.gap = (i == 0) ? first_gap : GAP_FD2;
            exp_q.push_back(e);
        end
        if (endk != END_NONE) begin
            e.kind = 1;
            e.r1 = 0; e.r2 = 0; e.c1 = 0; e.c2 = 0; e.addr = addr;
            e.cnt = (endk == END_NORM) ? nflips : 0;
            e.tmo = (endk == END_TMO) ? 1 : 0;
            e.gap = (endk == END_NORM) ? GAP_FD2 : GAP_START;
            exp_q.push_back(e);
        end
    endfunction

    // flip_controller model for the 4x4 instance.
    initial begin
        int idx, lat;
        fd_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && a_flip_start) begin
                idx = fs_cnt;
                fs_cnt++;
                if (idx < resp_upto) begin
                    lat = $urandom_range(lat_hi, lat_lo);
                    if (glitch_en) begin
                        fd_resp = 1'b1;
                        @(posedge clk);
                        #1 fd_resp = 1'b0;
                        repeat (lat - 1) @(posedge clk);
                    end else begin
                        repeat (lat) @(posedge clk);
                    end
                    #1 fd_resp = 1'b1;
                    last_fd_cyc = cyc;
                    @(posedge clk);
                    #1 fd_resp = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the 4x4 instance presents flip_start or done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && a_flip_start) begin
                if (exp_q.size() == 0) fail_now("flip_start_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("flip_kind", e.kind, 0);
                    chk("flip_r1", int'(a_r1), e.r1);
                    chk("flip_r2", int'(a_r2), e.r2);
                    chk("flip_c1", int'(a_c1), e.c1);
                    chk("flip_c2", int'(a_c2), e.c2);
                    chk("flip_addr", int'(a_flip_addr), e.addr);
                    if (e.gap == GAP_FD2) chk("flip_gap", cyc - last_fd_cyc, 2);
                    else if (e.gap == GAP_DONE2) chk("restart_gap", cyc - last_done_cyc, 2);
                    last_start_cyc = cyc;
                end
            end
            if (!reset && a_done) begin
                if (exp_q.size() == 0) fail_now("done_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", e.kind, 1);
                    chk("done_rect_count", int'(a_cnt), e.cnt);
                    chk("done_timeout_err", int'(a_tmo), e.tmo);
                    if (e.gap == GAP_FD2) chk("done_gap", cyc - last_fd_cyc, 2);
                    else if (e.gap == GAP_START) chk("timeout_gap", cyc - last_start_cyc, 1 + TMO_A);
                end
                last_done_cyc = cyc;
                done_seen++;
            end
        end
    end

    // flip_controller model for the 2x3 instance: fixed one-cycle latency, records corners.
    initial begin
        mrect_t m;
        b_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && b_flip_start) begin
                m.r1 = int'(b_r1); m.r2 = int'(b_r2); m.c1 = int'(b_c1); m.c2 = int'(b_c2);
                b_obs_q.push_back(m);
                chk("b_flip_addr", int'(b_flip_addr), int'(b_addr));
                @(posedge clk);
                #1 b_fd = 1'b1;
                @(posedge clk);
                #1 b_fd = 1'b0;
            end
            if (!reset && b_done) begin
                b_done_n++;
                b_done_cnt = int'(b_cnt);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_job_ready"}, int'(a_job_ready), 1);
        chk({tag, "_flip_start"}, int'(a_flip_start), 0);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_done"}, int'(a_done), 0);
        chk({tag, "_timeout_err"}, int'(a_tmo), 0);
        chk({tag, "_rect"}, int'({a_r1, a_r2, a_c1, a_c2}), 8'b00_01_00_01);
        chk({tag, "_rect_count"}, int'(a_cnt), 0);
        chk({tag, "_flip_base_addr"}, int'(a_flip_addr), 0);
    endtask

    task automatic start_job(input int addr);
        a_addr = 8'(addr);
        a_job_valid = 1'b1;
        @(posedge clk);
        #1 a_job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_job_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle_budget", exp_q.size(), 0);
    endtask

    task automatic wait_flips(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fs_cnt >= target) break;
        end
        chk("wait_flips_reached", int'(fs_cnt >= target), 1);
    endtask

    initial begin
        int addr, base, d0;
        reset = 1'b1;
        a_job_valid = 1'b0; a_addr = '0; a_abort = 1'b0; fd_force = 1'b0;
        b_job_valid = 1'b0; b_addr = '0; b_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("por");
        chk("b_por_job_ready", int'(b_job_ready), 1);
        chk("b_por_rect", int'({b_r1, b_r2, b_c1, b_c2}), 8'b00_01_00_01);

        // Full 4x4 job, base 0x10, flip_done 3 cycles after each flip_start.
        resp_upto = 1 << 30; lat_lo = 3; lat_hi = 3;
        push_job(32'h10, 36, END_NORM, GAP_NONE);
        start_job(32'h10);
        wait_idle(600);
        chk("job1_rect_count", int'(a_cnt), 36);
        chk("job1_timeout_err", int'(a_tmo), 0);

        // Controller never answers: watchdog ends the job.
        resp_upto = fs_cnt;
        addr = $urandom_range(255, 0);
        push_job(addr, 1, END_TMO, GAP_NONE);
        start_job(addr);
        wait_idle(100);
        chk("tmo_sticky", int'(a_tmo), 1);
        chk("tmo_rect_count", int'(a_cnt), 0);
        chk("tmo_flip_count", fs_cnt - resp_upto, 1);

        // Next accept clears timeout_err; random latencies.
        resp_upto = 1 << 30; lat_lo = 1; lat_hi = 6;
        addr = $urandom_range(255, 0);
        push_job(addr, 36, END_NORM, GAP_NONE);
        start_job(addr);
        @(negedge clk);
        chk("accept_clears_tmo", int'(a_tmo), 0);
        wait_idle(800);

        // Abort during the fifth WAIT.
        base = fs_cnt; resp_upto = base + 4;
        d0 = done_seen;
        addr = $urandom_range(255, 0);
        push_job(addr, 5, END_NONE, GAP_NONE);
        start_job(addr);
        wait_flips(base + 5, 400);
        repeat (2) @(posedge clk);
        #1 a_abort = 1'b1;
        @(posedge clk);
        #1 a_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_job_ready", int'(a_job_ready), 1);
        chk("abort_rect_count", int'(a_cnt), 4);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_no_more_flips", fs_cnt - base, 5);

        // Restart after abort begins again at the first rectangle.
        resp_upto = 1 << 30;
        addr = $urandom_range(255, 0);
        push_job(addr, 36, END_NORM, GAP_NONE);
        start_job(addr);
        wait_idle(800);

        // Reset mid-job after ten flips; a late flip_done must not count.
        base = fs_cnt; resp_upto = base + 10;
        addr = $urandom_range(255, 1);
        push_job(addr, 11, END_NONE, GAP_NONE);
        start_job(addr);
        wait_flips(base + 11, 400);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        fd_force = 1'b1;
        @(posedge clk);
        #1 fd_force = 1'b0;
        @(negedge clk);
        chk("late_done_count", int'(a_cnt), 0);
        chk("late_done_busy", int'(a_busy), 0);

        // job_valid held high across a job; flip_done also pulsed during ISSUE.
        resp_upto = 1 << 30; lat_lo = 2; lat_hi = 4; glitch_en = 1'b1;
        addr = $urandom_range(255, 0);
        push_job(addr, 36, END_NORM, GAP_NONE);
        push_job(addr, 36, END_NORM, GAP_DONE2);
        d0 = done_seen;
        a_addr = 8'(addr);
        a_job_valid = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (done_seen > d0) break;
        end
        chk("held_first_done", done_seen - d0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_busy) break;
        end
        chk("held_second_accept", int'(a_busy), 1);
        a_job_valid = 1'b0;
        wait_idle(800);
        glitch_en = 1'b0;
        chk("held_job_count", done_seen - d0, 2);

        // 2x3 instance: exactly three rectangles.
        b_addr = 8'($urandom_range(255, 0));
        b_job_valid = 1'b1;
        @(posedge clk);
        #1 b_job_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_done_n > 0) break;
        end
        chk("b_done_seen", b_done_n, 1);
        build_list(2, 3);
        chk("b_flip_count", b_obs_q.size(), model_q.size());
        for (int i = 0; i < model_q.size() && i < b_obs_q.size(); i++) begin
            chk("b_rect_r1", b_obs_q[i].r1, model_q[i].r1);
            chk("b_rect_r2", b_obs_q[i].r2, model_q[i].r2);
            chk("b_rect_c1", b_obs_q[i].c1, model_q[i].c1);
            chk("b_rect_c2", b_obs_q[i].c2, model_q[i].c2);
        end
        chk("b_rect_count", b_done_cnt, 3);
        @(negedge clk);
        chk("b_idle_busy", int'(b_busy), 0);
        chk("b_idle_ready", int'(b_job_ready), 1);
        chk("b_timeout_err", int'(b_tmo), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #300000;
        $display("FAIL global_time_limit act=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
